load_store_unit: RTL and testbench

- Sits between the processor core's data-memory port and the data memory / peripheral bus.
- Takes the core's single-cycle memory request (request, write, size, address, write data) and turns it into a registered, byte-enabled bus transaction with a ready handshake.
- Holds the core stalled until the transaction completes, then returns sign- or zero-extended load data.
- Adds a timeout counter that aborts transactions that never complete.

---
 rtl/load_store_unit.sv | 216 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Bridges the core's single-cycle data-memory request onto a registered,
// byte-enabled bus transaction with a ready handshake. The core is stalled
// until the bus completes; load data is returned sign- or zero-extended.
// A timeout counter aborts transactions that never see mem_ready_i.
//
// Parameters:
//   TIMEOUT_CYCLES : BUSY cycles without mem_ready_i before abort (0 = never)
//
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-low reset
//   core_req_i   : core requests a memory access
//   core_we_i    : 1 = store, 0 = load
//   core_size_i  : RISC-V funct3 (0 B, 1 H, 2 W, 4 BU, 5 HU; others act as W)
//   core_addr_i  : byte address
//   core_wd_i    : right-aligned store data
//   core_rd_o    : extended load result (registered)
//   core_stall_o : core must hold PC / suppress writeback
//   bus_err_o    : one-cycle pulse on timeout abort
//   mem_req_o    : bus request (high throughout BUSY)
//   mem_we_o     : bus write
//   mem_be_o     : byte enables
//   mem_addr_o   : word-aligned bus address
//   mem_wd_o     : lane-replicated store data
//   mem_rd_i     : bus read data, valid with mem_ready_i
//   mem_ready_i  : bus completes the transaction this cycle
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter only ever holds 0 .. TIMEOUT_CYCLES-1; the abort fires when
  // the last of those values is seen without a ready.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [3:0]        be_fmt;
  logic [31:0]       wd_fmt;
  logic [7:0]        rd_byte [4];
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic              ld_signed;
  logic [31:0]       load_ext;

  // ---------------------------------------------------------------------------
  // Request formatting (from the live core inputs, latched on acceptance).
  // Only size[1:0] selects the width: 4/5 are the unsigned B/H variants and
  // 3/6/7 fall through to full-word handling.
  // ---------------------------------------------------------------------------
  always_comb begin
    be_fmt = 4'b1111;
    wd_fmt = core_wd_i;
    case (core_size_i[1:0])
      2'b00: begin
        be_fmt = 4'b0001 << core_addr_i[1:0];
        wd_fmt = {4{core_wd_i[7:0]}};
      end
      2'b01: begin
        be_fmt = core_addr_i[1] ? 4'b1100 : 4'b0011;
        wd_fmt = {2{core_wd_i[15:0]}};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extraction (from the latched request and the bus read data).
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
    assign rd_byte[gi] = mem_rd_i[8*gi +: 8];
  end

  assign sel_byte  = rd_byte[addr_q[1:0]];
  assign sel_half  = addr_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
  assign ld_signed = ~size_q[2];

  always_comb begin
    load_ext = mem_rd_i;
    case (size_q[1:0])
      2'b00:   load_ext = {{24{ld_signed & sel_byte[7]}}, sel_byte};
      2'b01:   load_ext = {{16{ld_signed & sel_half[15]}}, sel_half};
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wd_d         = wd_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    err_d        = 1'b0;
    core_stall_o = 1'b0;
    mem_req_o    = 1'b0;

    case (state_q)
      IDLE: begin
        // Stall combinationally so the core holds its PC in the accept cycle.
        core_stall_o = core_req_i;
        if (core_req_i) begin
          we_d    = core_we_i;
          size_d  = core_size_i;
          addr_d  = core_addr_i;
          be_d    = be_fmt;
          wd_d    = wd_fmt;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        mem_req_o    = 1'b1;
        core_stall_o = 1'b1;
        if (mem_ready_i) begin
          if (!we_q) begin
            rd_d = load_ext;
          end
          cnt_d   = '0;
          state_d = DONE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          rd_d    = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // Retire cycle: never accept a new request here.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_we_o   = we_q;
  assign mem_be_o   = be_q;
  assign mem_addr_o = {addr_q[31:2], 2'b00};
  assign mem_wd_o   = wd_q;
  assign core_rd_o  = rd_q;
  assign bus_err_o  = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit. Instance dut uses the default timeout;
// instance dut_to uses TIMEOUT_CYCLES = 4 for the abort scenario. Inputs are
// driven 2 time units after the rising edge; outputs are checked 1 unit later.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        core_req_i = 1'b0;
  logic        core_req2 = 1'b0;
  logic        core_we_i = 1'b0;
  logic [2:0]  core_size_i = 3'd0;
  logic [31:0] core_addr_i = 32'd0;
  logic [31:0] core_wd_i = 32'd0;
  logic [31:0] mem_rd_i = 32'd0;
  logic        mem_ready_i = 1'b0;

  logic [31:0] core_rd_o, core_rd2;
  logic        core_stall_o, core_stall2;
  logic        bus_err_o, bus_err2;
  logic        mem_req_o, mem_req2;
  logic        mem_we_o, mem_we2;
  logic [3:0]  mem_be_o, mem_be2;
  logic [31:0] mem_addr_o, mem_addr2;
  logic [31:0] mem_wd_o, mem_wd2;

  int ncmp = 0;
  int nfail = 0;
  int bursts = 0;
  int err1_cnt = 0;
  int err2_cnt = 0;
  logic mreq_prev = 1'b0;

  always #5 clk_i = ~clk_i;

  load_store_unit dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .core_req_i  (core_req_i),
    .core_we_i   (core_we_i),
    .core_size_i (core_size_i),
    .core_addr_i (core_addr_i),
    .core_wd_i   (core_wd_i),
    .core_rd_o   (core_rd_o),
    .core_stall_o(core_stall_o),
    .bus_err_o   (bus_err_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wd_o    (mem_wd_o),
    .mem_rd_i    (mem_rd_i),
    .mem_ready_i (mem_ready_i)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .core_req_i  (core_req2),
    .core_we_i   (core_we_i),
    .core_size_i (core_size_i),
    .core_addr_i (core_addr_i),
    .core_wd_i   (core_wd_i),
    .core_rd_o   (core_rd2),
    .core_stall_o(core_stall2),
    .bus_err_o   (bus_err2),
    .mem_req_o   (mem_req2),
    .mem_we_o    (mem_we2),
    .mem_be_o    (mem_be2),
    .mem_addr_o  (mem_addr2),
    .mem_wd_o    (mem_wd2),
    .mem_rd_i    (mem_rd_i),
    .mem_ready_i (mem_ready_i)
  );

  // Count request bursts and error pulses, sampled on the falling edge.
  always @(negedge clk_i) begin
    mreq_prev <= mem_req_o;
    if (mem_req_o && !mreq_prev) bursts <= bursts + 1;
    if (bus_err_o) err1_cnt <= err1_cnt + 1;
    if (bus_err2) err2_cnt <= err2_cnt + 1;
  end

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One complete transaction with ready in the first BUSY cycle.
  task automatic xact(input string tag, input logic we, input logic [2:0] size,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rdata, input logic [3:0] exp_be,
                      input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                      input bit hold);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    settle();
    chk({tag, ".idle_stall"}, 32'(core_stall_o), 32'd1);
    chk({tag, ".idle_req"},   32'(mem_req_o),    32'd0);
    cyc();
    if (!hold) core_req_i = 1'b0;
    mem_ready_i = 1'b1;
    mem_rd_i    = rdata;
    settle();
    chk({tag, ".busy_req"},   32'(mem_req_o),    32'd1);
    chk({tag, ".busy_stall"}, 32'(core_stall_o), 32'd1);
    chk({tag, ".we"},         32'(mem_we_o),     32'(we));
    chk({tag, ".be"},         32'(mem_be_o),     32'(exp_be));
    chk({tag, ".addr"},       mem_addr_o,        {addr[31:2], 2'b00});
    chk({tag, ".wd"},         mem_wd_o,          exp_wd);
    cyc();
    mem_ready_i = 1'b0;
    mem_rd_i    = 32'h5A5A5A5A;
    settle();
    chk({tag, ".done_stall"}, 32'(core_stall_o), 32'd0);
    chk({tag, ".done_req"},   32'(mem_req_o),    32'd0);
    chk({tag, ".rd"},         core_rd_o,         exp_rd);
    chk({tag, ".err"},        32'(bus_err_o),    32'd0);
    $display("txn %-6s we=%0d size=%0d addr=%08h be=%h wd=%08h rd=%08h",
             tag, we, size, addr, mem_be_o, mem_wd_o, core_rd_o);
    cyc();
    core_req_i = 1'b0;
    settle();
    chk({tag, ".after_req"}, 32'(mem_req_o), 32'd0);
  endtask

  initial begin
    int stall_n;
    int b0;
    int e0;

    // ---- Reset state ----
    cyc();
    cyc();
    settle();
    chk("rst.rd",    core_rd_o,           32'd0);
    chk("rst.stall", 32'(core_stall_o),   32'd0);
    chk("rst.req",   32'(mem_req_o),      32'd0);
    chk("rst.err",   32'(bus_err_o),      32'd0);
    chk("rst.be",    32'(mem_be_o),       32'd0);
    chk("rst.addr",  mem_addr_o,          32'd0);
    rst_i = 1'b1;
    cyc();

    // ---- Single-wait transactions ----
    xact("LW",   1'b0, 3'd2, 32'h0000_0100, 32'h0,         32'hDEADBEEF, 4'hF, 32'h0,         32'hDEADBEEF, 1'b1);
    xact("LB",   1'b0, 3'd0, 32'h0000_0203, 32'h0000_00AB, 32'h80123456, 4'h8, 32'hABABABAB, 32'hFFFFFF80, 1'b0);
    xact("LBU",  1'b0, 3'd4, 32'h0000_0203, 32'h0000_00AB, 32'h80123456, 4'h8, 32'hABABABAB, 32'h00000080, 1'b0);
    xact("LH",   1'b0, 3'd1, 32'h0000_0202, 32'h0,         32'h80011234, 4'hC, 32'h0,         32'hFFFF8001, 1'b0);
    xact("LHU",  1'b0, 3'd5, 32'h0000_0101, 32'h0,         32'h1234F00D, 4'h3, 32'h0,         32'h0000F00D, 1'b0);
    xact("LB1",  1'b0, 3'd0, 32'h0000_0101, 32'h0,         32'h00007F00, 4'h2, 32'h0,         32'h0000007F, 1'b0);
    xact("SH",   1'b1, 3'd1, 32'h0000_0102, 32'h1234ABCD,  32'hFFFFFFFF, 4'hC, 32'hABCDABCD, 32'h0000007F, 1'b1);
    xact("SB",   1'b1, 3'd0, 32'h0000_0101, 32'h000000A5,  32'hFFFFFFFF, 4'h2, 32'hA5A5A5A5, 32'h0000007F, 1'b0);
    xact("SW3",  1'b1, 3'd3, 32'h0000_010B, 32'h87654321,  32'hFFFFFFFF, 4'hF, 32'h87654321, 32'h0000007F, 1'b0);
    xact("LW7",  1'b0, 3'd7, 32'h0000_020E, 32'h0,         32'h13579BDF, 4'hF, 32'h0,         32'h13579BDF, 1'b0);
    xact("LW6",  1'b0, 3'd6, 32'h0000_0301, 32'h0,         32'h8000_0001, 4'hF, 32'h0,        32'h80000001, 1'b0);

    // ---- Ready delayed 5 cycles: bus fields stable, 7 stall cycles ----
    b0 = bursts;
    stall_n = 0;
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h0000_0300;
    core_wd_i   = 32'h55AA55AA;
    settle();
    if (core_stall_o) stall_n++;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      core_req_i  = 1'b0;
      core_we_i   = 1'b1;
      core_size_i = 3'd0;
      core_addr_i = 32'hFFFF_FFFF;
      core_wd_i   = 32'h0;
      if (i == 6) begin
        mem_ready_i = 1'b1;
        mem_rd_i    = 32'h0BADF00D;
      end
      settle();
      if (core_stall_o) stall_n++;
      chk("dly.req",  32'(mem_req_o), 32'd1);
      chk("dly.addr", mem_addr_o,     32'h0000_0300);
      chk("dly.be",   32'(mem_be_o),  32'hF);
      chk("dly.we",   32'(mem_we_o),  32'd0);
      chk("dly.wd",   mem_wd_o,       32'h55AA55AA);
    end
    cyc();
    mem_ready_i = 1'b0;
    settle();
    if (core_stall_o) stall_n++;
    chk("dly.rd",   core_rd_o, 32'h0BADF00D);
    $display("txn LWdly  addr=00000300 rd=%08h stall_cycles=%0d", core_rd_o, stall_n);
    cyc();
    settle();
    chk("dly.stall_cycles", 32'(stall_n),      32'd7);
    chk("dly.bursts",       32'(bursts - b0),  32'd1);

    // ---- Timeout instance: prime core_rd with a good load first ----
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h0000_0400;
    core_req2   = 1'b1;
    settle();
    cyc();
    core_req2   = 1'b0;
    mem_ready_i = 1'b1;
    mem_rd_i    = 32'h11111111;
    settle();
    chk("to.prime_req", 32'(mem_req2), 32'd1);
    cyc();
    mem_ready_i = 1'b0;
    settle();
    chk("to.prime_rd", core_rd2, 32'h11111111);
    $display("txn LWto   addr=00000400 rd=%08h", core_rd2);
    cyc();

    e0 = err2_cnt;
    core_addr_i = 32'h0000_0404;
    core_req2   = 1'b1;
    settle();
    chk("to.idle_stall", 32'(core_stall2), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      core_req2 = 1'b0;
      settle();
      chk("to.busy_req",   32'(mem_req2),    32'd1);
      chk("to.busy_stall", 32'(core_stall2), 32'd1);
      chk("to.busy_err",   32'(bus_err2),    32'd0);
    end
    cyc();
    settle();
    chk("to.done_err",   32'(bus_err2),    32'd1);
    chk("to.done_stall", 32'(core_stall2), 32'd0);
    chk("to.done_rd",    core_rd2,         32'd0);
    chk("to.done_req",   32'(mem_req2),    32'd0);
    $display("txn LWabort addr=00000404 err=%0d rd=%08h", bus_err2, core_rd2);
    cyc();
    settle();
    chk("to.idle_err",  32'(bus_err2),        32'd0);
    chk("to.idle_req",  32'(mem_req2),        32'd0);
    chk("to.pulses",    32'(err2_cnt - e0),   32'd1);

    // ---- Asynchronous reset during BUSY ----
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h0000_0500;
    settle();
    cyc();
    core_req_i = 1'b0;
    settle();
    chk("arst.busy_req", 32'(mem_req_o), 32'd1);
    #3;
    rst_i = 1'b0;
    #1;
    chk("arst.req",   32'(mem_req_o),    32'd0);
    chk("arst.stall", 32'(core_stall_o), 32'd0);
    chk("arst.err",   32'(bus_err_o),    32'd0);
    chk("arst.rd",    core_rd_o,         32'd0);
    chk("arst.be",    32'(mem_be_o),     32'd0);
    $display("txn RSTbusy addr=00000500 aborted");
    cyc();
    settle();
    chk("arst.hold_req", 32'(mem_req_o), 32'd0);
    chk("arst.hold_err", 32'(bus_err_o), 32'd0);
    rst_i = 1'b1;
    cyc();

    // ---- Back-to-back after reset ----
    xact("LWr",  1'b0, 3'd2, 32'h0000_0600, 32'h0,        32'hCAFEBABE, 4'hF, 32'h0,        32'hCAFEBABE, 1'b0);
    xact("SWr",  1'b1, 3'd2, 32'h0000_0604, 32'h01020304, 32'hFFFFFFFF, 4'hF, 32'h01020304, 32'hCAFEBABE, 1'b0);

    cyc();
    chk("main.err_pulses", 32'(err1_cnt), 32'd0);
    chk("to.err_pulses",   32'(err2_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
